// File: rtl/panda_risc_v_pkg.sv
// Shared definitions for the panda RISC-V dispatch stage: execution channel
// indices and the architectural register-index width.
package panda_risc_v_pkg;

    // Width of a source/destination register index (x0..x31).
    localparam int unsigned REG_ID_W = 5;

    // Execution channel indices; bit k of a unit-select vector targets channel k.
    typedef enum logic [3:0] {
        DSPTC_CH_ALU = 4'd0,
        DSPTC_CH_BCU = 4'd1,
        DSPTC_CH_LSU = 4'd2,
        DSPTC_CH_CSR = 4'd3,
        DSPTC_CH_MUL = 4'd4,
        DSPTC_CH_DIV = 4'd5
    } dsptc_ch_e;

    // Number of channels in the standard configuration.
    localparam int unsigned DSPTC_STD_CH_N = 6;

endpackage

// File: rtl/panda_risc_v_dsptc_fifo.sv
// In-order dispatch queue. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter. Payload
// storage is deliberately left unreset; only the pointers are cleared.
module panda_risc_v_dsptc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o & ~clr_i;
    assign do_pop  = pop_i & ~empty_o & ~clr_i;

    // Pointer next-state: a clear wins over any push or pop in the same cycle.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        end
    end

    // Pointer registers, cleared asynchronously so the queue empties at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Payload write; no reset so the storage maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/panda_risc_v_multi_dsptc.sv
// Multi-channel instruction dispatcher: queues decoded instructions in order,
// holds the head while a RAW hazard is reported, and routes it to the one
// execution channel selected by the lowest set bit of its unit-select.
// Optional feature macro: PANDA_RISC_V_MULTI_DSPTC_PERF_CNT_EN adds three
// 32-bit performance counters (pops, RAW stall cycles, full-stall cycles).
module panda_risc_v_multi_dsptc
    import panda_risc_v_pkg::*;
#(
    parameter int simulation_delay = 1,
    parameter int DATA_WIDTH       = 128,
    parameter int CH_N             = DSPTC_STD_CH_N,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       sys_resetn,
    input  logic                       flush_req,

    input  logic [DATA_WIDTH-1:0]      s_dcd_data,
    input  logic [CH_N-1:0]            s_dcd_unit_sel,
    input  logic [REG_ID_W-1:0]        s_dcd_rs1_id,
    input  logic [REG_ID_W-1:0]        s_dcd_rs2_id,
    input  logic                       s_dcd_valid,
    output logic                       s_dcd_ready,

    output logic [REG_ID_W-1:0]        raw_dpc_check_rs1_id,
    output logic [REG_ID_W-1:0]        raw_dpc_check_rs2_id,
    input  logic                       rs1_raw_dpc,
    input  logic                       rs2_raw_dpc,

    output logic [CH_N*DATA_WIDTH-1:0] m_dsptc_data,
    output logic [CH_N-1:0]            m_dsptc_valid,
    input  logic [CH_N-1:0]            m_dsptc_ready,

    output logic                       queue_empty
`ifdef PANDA_RISC_V_MULTI_DSPTC_PERF_CNT_EN
    ,
    output logic [31:0]                perf_dsptc_cnt,
    output logic [31:0]                perf_raw_stall_cnt,
    output logic [31:0]                perf_full_cnt
`endif
);

    // Elaboration-time parameter legality.
    if (simulation_delay < 0) begin : g_bad_sim_delay
        $error("simulation_delay must be non-negative");
    end
    if (CH_N < 1 || CH_N > 16) begin : g_bad_ch_n
        $error("CH_N must be within 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    // Queue entry layout: {data, unit_sel, rs1_id, rs2_id}.
    localparam int ENTRY_W = DATA_WIDTH + CH_N + 2 * REG_ID_W;

    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head_entry;
    logic [DATA_WIDTH-1:0] head_data;
    logic [CH_N-1:0]       head_sel;
    logic [REG_ID_W-1:0]   head_rs1;
    logic [REG_ID_W-1:0]   head_rs2;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  hazard;
    logic                  issue_ok;
    logic [CH_N-1:0]       route_sel;

    assign wr_entry = {s_dcd_data, s_dcd_unit_sel, s_dcd_rs1_id, s_dcd_rs2_id};
    assign {head_data, head_sel, head_rs1, head_rs2} = head_entry;

    // Upstream handshake; flush discards a push offered in the same cycle.
    assign s_dcd_ready = ~full;
    assign push        = s_dcd_valid & ~full & ~flush_req;
    assign queue_empty = empty;

    // RAW check is against the head entry's source registers.
    assign raw_dpc_check_rs1_id = head_rs1;
    assign raw_dpc_check_rs2_id = head_rs2;
    assign hazard               = ~empty & (rs1_raw_dpc | rs2_raw_dpc);

    // Head may leave the queue only when present, hazard-free and not flushed.
    assign issue_ok = ~empty & ~hazard & ~flush_req;

    // Isolate the lowest set bit so a multi-hot select reaches one channel only.
    assign route_sel = head_sel & (~head_sel + CH_N'(1));

    assign m_dsptc_valid = route_sel & {CH_N{issue_ok}};
    assign m_dsptc_data  = {CH_N{head_data}};

    // Pop on the routed channel's handshake; a no-execute head drains by itself.
    assign pop = issue_ok & ((route_sel == '0) | (|(route_sel & m_dsptc_ready)));

    panda_risc_v_dsptc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (sys_resetn),
        .clr_i   (flush_req),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (head_entry),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef PANDA_RISC_V_MULTI_DSPTC_PERF_CNT_EN
    logic [31:0] dsptc_cnt_q, dsptc_cnt_d;
    logic [31:0] raw_stall_cnt_q, raw_stall_cnt_d;
    logic [31:0] full_cnt_q, full_cnt_d;

    // Counter next-state; each wraps naturally at 2^32.
    always_comb begin
        dsptc_cnt_d     = dsptc_cnt_q;
        raw_stall_cnt_d = raw_stall_cnt_q;
        full_cnt_d      = full_cnt_q;
        if (pop)                 dsptc_cnt_d     = dsptc_cnt_q + 32'd1;
        if (hazard)              raw_stall_cnt_d = raw_stall_cnt_q + 32'd1;
        if (s_dcd_valid & full)  full_cnt_d      = full_cnt_q + 32'd1;
    end

    // Counter registers, cleared only by reset (flush leaves them alone).
    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            dsptc_cnt_q     <= '0;
            raw_stall_cnt_q <= '0;
            full_cnt_q      <= '0;
        end else begin
            dsptc_cnt_q     <= dsptc_cnt_d;
            raw_stall_cnt_q <= raw_stall_cnt_d;
            full_cnt_q      <= full_cnt_d;
        end
    end

    assign perf_dsptc_cnt     = dsptc_cnt_q;
    assign perf_raw_stall_cnt = raw_stall_cnt_q;
    assign perf_full_cnt      = full_cnt_q;
`endif

endmodule
